mdr_unit: RTL and testbench
===========================

// Module: mdr_unit
// PURPOSE
//  Parametrised Memory Data Register with integrated memory-side handshake FSM.
//  Bus side loads from BusMuxOut; memory side runs req/ack read and write transactions.
//  Read data is size-formatted (byte/half/word, sign- or zero-extended) before capture.
//  Sits between the internal bus and the RAM port; output q drives the bus MDRout source and RAM wdata.
// PARAMETERS
//  DATA_W   32  data width; multiple of 8, >=16
//  TO_CYC   15  wait cycles before a transaction times out (MDR_TIMEOUT_EN only); 1..255
// PORTS
//  clk          in   1       clock; all state updates on rising edge
//  clr          in   1       synchronous reset, active-high
//  BusMuxOut    in   DATA_W  internal bus value
//  MDRin        in   1       load q from BusMuxOut (IDLE only)
//  rd_start     in   1       begin memory read transaction
//  wr_start     in   1       begin memory write transaction (writes current q)
//  ld_size      in   2       read format: 00 word, 01 half, 10 byte, 11 word
//  ld_signed    in   1       1 = sign-extend half/byte, 0 = zero-extend
//  mem_rdata    in   DATA_W  memory read data, valid when mem_ack=1
//  mem_ack      in   1       memory completion strobe
//  q            out  DATA_W  MDR contents
//  mem_req      out  1       transaction request, held until ack/timeout
//  mem_we       out  1       1 = write transaction
//  mem_wdata    out  DATA_W  write data (= q)
//  busy         out  1       FSM not in IDLE
//  done         out  1       one-cycle pulse on transaction completion
//  timeout_err  out  1       sticky timeout flag
// BEHAVIOUR
//  Reset (clr=1 at edge): q=0, state=IDLE, mem_req=0, mem_we=0, done=0, timeout_err=0, counter=0.
//  clr overrides everything including an in-flight transaction; no done pulse; request dropped next cycle.
//  States: IDLE, RD_WAIT, WR_WAIT.
//  IDLE: rd_start -> RD_WAIT; else wr_start -> WR_WAIT; else MDRin -> q<=BusMuxOut.
//   rd_start and wr_start together: read wins, write dropped. rd/wr_start with MDRin: start wins, MDRin ignored.
//   ld_size/ld_signed sampled at rd_start and held for the transaction.
//  RD_WAIT/WR_WAIT: mem_req=1, mem_we=(state==WR_WAIT), registered outputs asserted the cycle after start.
//   mem_ack=1: RD: q<=format(mem_rdata); WR: q unchanged; done=1 next cycle; -> IDLE.
//   MDRin, rd_start, wr_start ignored while busy (no queueing).
//  Back-to-back: start may be accepted in the cycle done is high (FSM already IDLE).
//  Format: half -> bits[15:0] extended per ld_signed; byte -> bits[7:0]; word/11 -> unmodified.
//  mem_wdata = q combinationally; q stable throughout WR_WAIT.
// CONFIGURATION
//  MDR_TIMEOUT_EN defined: counter counts cycles in RD_WAIT/WR_WAIT; reset on entry.
//   Reaching TO_CYC without ack -> IDLE, q unchanged, done pulse, timeout_err<=1 (cleared only by clr).
//   ack arriving in the timeout cycle counts as success (ack wins).
//  MDR_TIMEOUT_EN undefined: no counter; wait indefinitely; timeout_err tied 0.
// STRUCTURE
//  mdr_pkg: state encodings (ST_IDLE/ST_RD_WAIT/ST_WR_WAIT), size codes (SZ_WORD/SZ_HALF/SZ_BYTE).
//  Sub-module mdr_extend: combinational formatter (data, size, signed -> DATA_W result).
//  Top: FSM, q register, latched size/signed, optional timeout counter.
// TESTING
//  Reset: drive garbage, clr=1 -> q=0, mem_req=0, busy=0, done=0, timeout_err=0.
//  Bus load: MDRin=1, BusMuxOut=0xDEADBEEF -> q=0xDEADBEEF next edge, no mem_req.
//  Read signed byte: rd_start, size=10, signed=1, ack after 3 cycles with rdata=0x000000F0
//   -> q=0xFFFFFFF0, done pulse 1 cycle; half zero-ext of 0x1234ABCD -> 0x0000ABCD.
//  Write: q=0x5A5A5A5A, wr_start -> mem_req=1, mem_we=1, mem_wdata=0x5A5A5A5A until ack; q unchanged.
//  Collisions: rd_start+wr_start+MDRin same cycle -> read only; MDRin during RD_WAIT leaves q unchanged.
//  Timeout (MDR_TIMEOUT_EN, TO_CYC=4): no ack -> done after 4 wait cycles, timeout_err=1, q held;
//   clr mid-RD_WAIT -> IDLE, no done.

Source files
------------

// File: rtl/mdr_pkg.sv
// Shared state encodings and read-format size codes for the MDR unit.
package mdr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR_WAIT = 2'd2
  } mdr_state_t;

  localparam logic [1:0] SZ_WORD     = 2'b00;
  localparam logic [1:0] SZ_HALF     = 2'b01;
  localparam logic [1:0] SZ_BYTE     = 2'b10;
  localparam logic [1:0] SZ_WORD_ALT = 2'b11;

endpackage

// File: rtl/mdr_extend.sv
// Combinational read-data formatter: selects word/half/byte and sign- or zero-extends.
module mdr_extend
  import mdr_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W-1:0] half_val;
  logic [DATA_W-1:0] byte_val;

  // Fill with the extension bit first, then overlay the selected low field.
  always_comb begin
    half_val       = {DATA_W{sign_ext & data[15]}};
    half_val[15:0] = data[15:0];
    byte_val       = {DATA_W{sign_ext & data[7]}};
    byte_val[7:0]  = data[7:0];
    case (size)
      SZ_HALF: result = half_val;
      SZ_BYTE: result = byte_val;
      default: result = data;
    endcase
  end

endmodule

// File: rtl/mdr_unit.sv
// Memory Data Register with req/ack memory handshake FSM and size-formatted reads.
// Optional MDR_TIMEOUT_EN adds a per-transaction wait counter and sticky timeout flag.
module mdr_unit
  import mdr_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TO_CYC = 15
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic              MDRin,
  input  logic              rd_start,
  input  logic              wr_start,
  input  logic [1:0]        ld_size,
  input  logic              ld_signed,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] q,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              timeout_err
);

  mdr_state_t        state, state_next;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [DATA_W-1:0] fmt_data;
  logic              waiting;
  logic              timeout_hit;

  assign waiting = (state != ST_IDLE);

  mdr_extend #(.DATA_W(DATA_W)) u_extend (
    .data    (mem_rdata),
    .size    (size_q),
    .sign_ext(signed_q),
    .result  (fmt_data)
  );

`ifdef MDR_TIMEOUT_EN
  logic [7:0] wait_cnt;

  // Counter sits at zero in IDLE so each transaction starts counting fresh.
  always_ff @(posedge clk) begin
    if (clr)           wait_cnt <= '0;
    else if (!waiting) wait_cnt <= '0;
    else               wait_cnt <= wait_cnt + 8'd1;
  end

  assign timeout_hit = waiting && (wait_cnt == 8'(TO_CYC - 1)) && !mem_ack;

  always_ff @(posedge clk) begin
    if (clr)              timeout_err <= 1'b0;
    else if (timeout_hit) timeout_err <= 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (clr) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Read has priority over write; starts are only honoured from IDLE.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (rd_start)      state_next = ST_RD_WAIT;
        else if (wr_start) state_next = ST_WR_WAIT;
      end
      ST_RD_WAIT, ST_WR_WAIT: begin
        if (mem_ack || timeout_hit) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_req   = waiting;
    mem_we    = (state == ST_WR_WAIT);
    busy      = waiting;
    mem_wdata = q;
  end

  always_ff @(posedge clk) begin
    if (clr) done <= 1'b0;
    else     done <= waiting && (mem_ack || timeout_hit);
  end

  // Format controls are captured at read start so they need not be held by the source.
  always_ff @(posedge clk) begin
    if (clr) begin
      size_q   <= SZ_WORD;
      signed_q <= 1'b0;
    end else if (state == ST_IDLE && rd_start) begin
      size_q   <= ld_size;
      signed_q <= ld_signed;
    end
  end

  always_ff @(posedge clk) begin
    if (clr)
      q <= '0;
    else if (state == ST_IDLE && !rd_start && !wr_start && MDRin)
      q <= BusMuxOut;
    else if (state == ST_RD_WAIT && mem_ack)
      q <= fmt_data;
  end

endmodule

// File: tb/tb_mdr_unit.sv
// Self-checking bench for mdr_unit: directed steps plus randomized load/read/write traffic.
module tb_mdr_unit;

  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          clr;
  logic [DW-1:0] BusMuxOut;
  logic          MDRin;
  logic          rd_start;
  logic          wr_start;
  logic [1:0]    ld_size;
  logic          ld_signed;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic [DW-1:0] q;
  logic          mem_req;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic          busy;
  logic          done;
  logic          timeout_err;

  int            tests = 0;
  int            fails = 0;
  logic [31:0]   exp_q;
  logic          exp_terr;

  always #5 clk = ~clk;

  mdr_unit #(.DATA_W(DW), .TO_CYC(TO)) dut (
    .clk        (clk),
    .clr        (clr),
    .BusMuxOut  (BusMuxOut),
    .MDRin      (MDRin),
    .rd_start   (rd_start),
    .wr_start   (wr_start),
    .ld_size    (ld_size),
    .ld_signed  (ld_signed),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .q          (q),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .timeout_err(timeout_err)
  );

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference formatter built from plain arithmetic on the field value.
  function automatic logic [31:0] fmtModel(input logic [31:0] d, input logic [1:0] sz, input logic sg);
    longint v;
    v = {32'b0, d};
    case (sz)
      2'b01: begin
        v = v % 65536;
        if (sg && v >= 32768) v = v - 65536;
      end
      2'b10: begin
        v = v % 256;
        if (sg && v >= 128) v = v - 256;
      end
      default: v = {32'b0, d};
    endcase
    return v[31:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // Drive one cycle's worth of inputs, then step past the next rising edge.
  task automatic applyStimulus(input logic m, input logic [31:0] bus, input logic rs, input logic ws,
                               input logic [1:0] sz, input logic sg, input logic ack, input logic [31:0] rdata);
    MDRin     = m;
    BusMuxOut = bus;
    rd_start  = rs;
    wr_start  = ws;
    ld_size   = sz;
    ld_signed = sg;
    mem_ack   = ack;
    mem_rdata = rdata;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, $urandom, 1'b0, 1'b0, 2'($urandom), 1'($urandom), 1'b0, $urandom);
  endtask

  task automatic doLoad(input logic [31:0] v);
    applyStimulus(1'b1, v, 1'b0, 1'b0, 2'($urandom), 1'($urandom), 1'b0, $urandom);
    exp_q = v;
    checkOutput("load_q", q, exp_q);
    checkBit("load_noreq", mem_req, 1'b0);
  endtask

  // lat = wait cycles without ack before the ack cycle (kept below TO so ack always wins).
  task automatic doRead(input logic [31:0] rdata, input logic [1:0] sz, input logic sg, input int lat);
    applyStimulus(1'b0, $urandom, 1'b1, 1'b0, sz, sg, 1'b0, $urandom);
    checkBit("rd_req", mem_req, 1'b1);
    checkBit("rd_we", mem_we, 1'b0);
    checkBit("rd_done_low", done, 1'b0);
    for (int i = 0; i < lat; i++) begin
      applyStimulus(1'b1, $urandom, 1'b1, 1'b1, ~sz, ~sg, 1'b0, $urandom);
      checkOutput("rd_hold_q", q, exp_q);
      checkBit("rd_busy", busy, 1'b1);
    end
    applyStimulus(1'b0, $urandom, 1'b0, 1'b0, ~sz, ~sg, 1'b1, rdata);
    exp_q = fmtModel(rdata, sz, sg);
    checkBit("rd_done", done, 1'b1);
    checkOutput("rd_q", q, exp_q);
    checkBit("rd_idle", busy, 1'b0);
    checkBit("rd_terr", timeout_err, exp_terr);
  endtask

  task automatic doWrite(input int lat);
    applyStimulus(1'b0, $urandom, 1'b0, 1'b1, 2'($urandom), 1'($urandom), 1'b0, $urandom);
    checkBit("wr_req", mem_req, 1'b1);
    checkBit("wr_we", mem_we, 1'b1);
    checkBit("wr_done_low", done, 1'b0);
    checkOutput("wr_wdata", mem_wdata, exp_q);
    for (int i = 0; i < lat; i++) begin
      applyStimulus(1'b1, $urandom, 1'b1, 1'b1, 2'($urandom), 1'($urandom), 1'b0, $urandom);
      checkOutput("wr_hold_wdata", mem_wdata, exp_q);
      checkBit("wr_hold_req", mem_req, 1'b1);
    end
    applyStimulus(1'b0, $urandom, 1'b0, 1'b0, 2'($urandom), 1'($urandom), 1'b1, $urandom);
    checkBit("wr_done", done, 1'b1);
    checkOutput("wr_q", q, exp_q);
    checkBit("wr_idle", mem_req, 1'b0);
  endtask

  initial begin
    logic [31:0] r;
    logic [1:0]  sz;
    logic        sg;

    exp_q    = '0;
    exp_terr = 1'b0;

    // Reset with garbage on every input, including a pending start.
    clr = 1'b1;
    applyStimulus(1'b1, $urandom, 1'b1, 1'b1, 2'($urandom), 1'b1, 1'b1, $urandom);
    applyStimulus(1'b1, $urandom, 1'b1, 1'b1, 2'($urandom), 1'b1, 1'b1, $urandom);
    checkOutput("rst_q", q, 32'h0);
    checkBit("rst_req", mem_req, 1'b0);
    checkBit("rst_busy", busy, 1'b0);
    checkBit("rst_done", done, 1'b0);
    checkBit("rst_terr", timeout_err, 1'b0);
    clr = 1'b0;
    idleCycle();

    doLoad(32'hDEADBEEF);
    doRead(32'h000000F0, 2'b10, 1'b1, 3);
    checkOutput("sbyte_q", q, 32'hFFFFFFF0);
    idleCycle();
    checkBit("done_pulse_len", done, 1'b0);
    doRead(32'h1234ABCD, 2'b01, 1'b0, 1);
    checkOutput("uhalf_q", q, 32'h0000ABCD);

    // Write issued in the same cycle the read's done pulse is high.
    doLoad(32'h5A5A5A5A);
    doRead(32'h5A5A5A5A, 2'b11, 1'b1, 0);
    doWrite(2);
    checkOutput("wr_q_fixed", q, 32'h5A5A5A5A);
    idleCycle();

    // Simultaneous read, write and load: only the read happens.
    applyStimulus(1'b1, 32'h11111111, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, $urandom);
    checkBit("col_req", mem_req, 1'b1);
    checkBit("col_we", mem_we, 1'b0);
    checkOutput("col_q", q, exp_q);
    applyStimulus(1'b1, 32'h22222222, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, $urandom);
    checkOutput("col_mdrin_ign", q, exp_q);
    applyStimulus(1'b0, $urandom, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 32'hCAFEF00D);
    exp_q = 32'hCAFEF00D;
    checkOutput("col_rd_q", q, exp_q);
    checkBit("col_done", done, 1'b1);
    idleCycle();

    // Randomized traffic against the reference model.
    repeat (30) begin
      r  = $urandom;
      sz = 2'($urandom);
      sg = 1'($urandom);
      case ($urandom_range(0, 2))
        0:       doLoad(r);
        1:       doRead(r, sz, sg, $urandom_range(0, TO - 1));
        default: doWrite($urandom_range(0, TO - 1));
      endcase
      if ($urandom_range(0, 1) == 1) idleCycle();
    end
    idleCycle();

`ifdef MDR_TIMEOUT_EN
    applyStimulus(1'b0, $urandom, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, $urandom);
    for (int i = 0; i < TO - 1; i++) begin
      idleCycle();
      checkBit("to_busy", busy, 1'b1);
      checkBit("to_done_low", done, 1'b0);
    end
    idleCycle();
    exp_terr = 1'b1;
    checkBit("to_done", done, 1'b1);
    checkBit("to_idle", busy, 1'b0);
    checkBit("to_terr", timeout_err, exp_terr);
    checkOutput("to_q", q, exp_q);
    idleCycle();
    checkBit("to_terr_sticky", timeout_err, 1'b1);
`else
    applyStimulus(1'b0, $urandom, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, $urandom);
    repeat (3 * TO) idleCycle();
    checkBit("noto_busy", busy, 1'b1);
    checkBit("noto_terr", timeout_err, 1'b0);
    checkBit("noto_done", done, 1'b0);
    applyStimulus(1'b0, $urandom, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 32'h0BADF00D);
    exp_q = 32'h0BADF00D;
    checkOutput("noto_q", q, exp_q);
    idleCycle();
`endif

    // Reset in the middle of a read: no done pulse, everything cleared.
    applyStimulus(1'b0, $urandom, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, $urandom);
    idleCycle();
    clr = 1'b1;
    applyStimulus(1'b0, $urandom, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, $urandom);
    exp_q    = '0;
    exp_terr = 1'b0;
    checkBit("clr_busy", busy, 1'b0);
    checkBit("clr_req", mem_req, 1'b0);
    checkBit("clr_done", done, 1'b0);
    checkOutput("clr_q", q, exp_q);
    checkBit("clr_terr", timeout_err, exp_terr);
    clr = 1'b0;
    idleCycle();
    checkBit("clr_no_late_done", done, 1'b0);
    checkBit("clr_still_idle", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
